// File: rtl/au_normalize_seq_pkg.sv
// Shared definitions for the sequential leading-zero normalizer:
// FSM state encoding and the constant ceil(log2) helper used to size
// the shift-stage and count fields.
package au_normalize_seq_pkg;

    // Controller states; encodings are fixed so that state dumps read the
    // same across every instance of the block.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } au_state_e;

    // ceil(log2(n)) for n >= 1, usable in constant expressions.
    function automatic int au_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage : au_normalize_seq_pkg

// File: rtl/au_normalize_seq_if.sv
// Handshake bundle of the normalizer: an input word channel (in_valid /
// in_ready / a) and a result channel (out_valid / out_ready / z / cnt /
// no_det). The producer/consumer side uses the master modport, the
// normalizer itself uses the slave modport.
interface au_normalize_seq_if
    import au_normalize_seq_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = au_clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic [CW-1:0]    cnt;
    logic             no_det;

    modport master (
        output in_valid,
        output a,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  z,
        input  cnt,
        input  no_det
    );

    modport slave (
        input  in_valid,
        input  a,
        input  out_ready,
        output in_ready,
        output out_valid,
        output z,
        output cnt,
        output no_det
    );

endinterface : au_normalize_seq_if

// File: rtl/au_normalize_seq.sv
// Sequential normalizer: shifts an input word left until its MSB is set,
// reporting the number of leading zeroes. One binary-search stage per
// clock: stage s tests the top 2^s bits and shifts by 2^s when they are
// all zero. With L = clog2(WIDTH) stages the shift amounts sum to
// 2^L - 1 >= WIDTH - 1, so every leading-zero count is reachable, and a
// stage only shifts when the leading '1' lies below the tested field, so
// it can never be shifted out (this also holds for non-power-of-two
// WIDTH, where 2^(L-1) < WIDTH).
//
// Timing: counting the acceptance edge as edge 1, an all-zero word is in
// DONE after 1 edge and any other word after L+1 edges.
module au_normalize_seq
    import au_normalize_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    au_normalize_seq_if.slave  nrm_if
);

    localparam int L  = au_clog2(WIDTH);
    localparam int CW = au_clog2(WIDTH + 1);

    // Elaboration-time guard: a single-bit word has nothing to normalize.
    generate
        if (WIDTH < 2) begin : g_width_check
            $fatal(1, "au_normalize_seq: WIDTH must be >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    au_state_e        state_q,     state_d;
    logic [WIDTH-1:0] work_q,      work_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [CW-1:0]    stage_q,     stage_d;
    logic             no_det_q,    no_det_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    // Shared shift stage signals
    logic [CW-1:0]    shift_amt_s;
    logic [WIDTH-1:0] shifted_s;
    logic             top_zero_s;

    // True when the top 'amt' bits of 'word' are all zero.
    function automatic logic top_bits_zero(input logic [WIDTH-1:0] word,
                                           input logic [CW-1:0]    amt);
        logic [WIDTH-1:0] upper;
        upper = word >> (WIDTH - int'(amt));
        return (upper == '0);
    endfunction

    // Single shift stage: amount 2^s, field test and zero-filled shift.
    always_comb begin
        shift_amt_s = CW'(1) << stage_q;
        shifted_s   = work_q << shift_amt_s;
        top_zero_s  = top_bits_zero(work_q, shift_amt_s);
    end

    // Next-state and datapath update for IDLE -> SHIFT/DONE -> IDLE.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        no_det_d    = no_det_q;

        case (state_q)
            ST_IDLE: begin
                if (nrm_if.in_valid) begin
                    work_d  = nrm_if.a;
                    stage_d = CW'(L - 1);
                    if (nrm_if.a == '0) begin
                        // Nothing to search for: report immediately.
                        state_d  = ST_DONE;
                        cnt_d    = CW'(WIDTH);
                        no_det_d = 1'b1;
                    end else begin
                        state_d  = ST_SHIFT;
                        cnt_d    = '0;
                        no_det_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (top_zero_s) begin
                    work_d = shifted_s;
                    cnt_d  = cnt_q + shift_amt_s;
                end else begin
                    work_d = work_q;
                    cnt_d  = cnt_q;
                end
                if (stage_q == '0) begin
                    state_d = ST_DONE;
                    stage_d = '0;
                end else begin
                    state_d = ST_SHIFT;
                    stage_d = stage_q - CW'(1);
                end
            end

            ST_DONE: begin
                if (nrm_if.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags follow the state they will be registered with.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // Controller and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            stage_q     <= '0;
            no_det_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            no_det_q    <= no_det_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Result and handshake outputs come straight from registers.
    assign nrm_if.in_ready  = in_ready_q;
    assign nrm_if.out_valid = out_valid_q;
    assign nrm_if.z         = work_q;
    assign nrm_if.cnt       = cnt_q;
    assign nrm_if.no_det    = no_det_q;

endmodule : au_normalize_seq

// File: tb/tb_au_normalize_seq.sv
// Bench for au_normalize_seq (WIDTH=8). A leading-zero model predicts each
// accepted word's result; a negedge process compares it every DONE cycle.
// Directed words also carry hand-computed expectations.
module tb_au_normalize_seq;

    localparam int W   = 8;
    localparam int LAT = 4;   // edges to DONE for a nonzero word (L+1)

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    au_normalize_seq_if #(.WIDTH(W)) nif ();

    au_normalize_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .nrm_if (nif)
    );

    typedef struct {
        logic [7:0] z;
        logic [3:0] cnt;
        logic       nd;
        int         lat;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;
    int   res_cnt = 0;
    logic prev_ov = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Result from first principles: count zeroes above the highest '1'.
    function automatic exp_t model(input logic [7:0] av);
        exp_t e;
        int   lz;
        lz = 8;
        for (int i = 0; i < 8; i++) begin
            if (av[i]) lz = 7 - i;
        end
        e.cnt = 4'(lz);
        e.z   = (lz >= 8) ? 8'h00 : 8'(av << lz);
        e.nd  = (av == 8'h00);
        e.lat = (av == 8'h00) ? 1 : LAT;
        e.acc = 0;
        return e;
    endfunction

    // Compare + scoreboard: inputs change only just after posedge, so at
    // negedge everything is stable and a seen handshake fires next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_ov = 1'b0;
            end else begin
                cyc++;
                if (nif.out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("out_valid_without_word", 32'd1, 32'd0);
                    end else begin
                        chk("model_z", 32'(nif.z), 32'(exp_q[0].z));
                        chk("model_cnt", 32'(nif.cnt), 32'(exp_q[0].cnt));
                        chk("model_no_det", 32'(nif.no_det), 32'(exp_q[0].nd));
                        chk("done_in_ready", 32'(nif.in_ready), 32'd0);
                        if (!prev_ov) begin
                            chk("model_latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                        end
                    end
                end
                if (nif.out_valid && nif.out_ready) begin
                    res_cnt++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (nif.in_valid && nif.in_ready) begin
                    e     = model(nif.a);
                    e.acc = cyc;
                    exp_q.push_back(e);
                    acc_cnt++;
                end
                prev_ov = nif.out_valid;
            end
        end
    end

    // One directed word with literal expectations and a DONE hold time.
    task automatic send(input logic [7:0] av, input logic [7:0] ez, input logic [3:0] ec,
                        input logic en, input int edges, input int hold);
        int n;
        n = 0;
        while (!nif.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle", 32'(nif.in_ready), 32'd1);
        nif.a         = av;
        nif.in_valid  = 1'b1;
        nif.out_ready = 1'b0;
        @(posedge clk); #1;
        // Junk while busy must be ignored.
        nif.a        = ~av;
        nif.in_valid = 1'b1;
        n = 1;
        while (!nif.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        nif.in_valid = 1'b0;
        chk("edges_to_done", 32'(n), 32'(edges));
        chk("lit_z", 32'(nif.z), 32'(ez));
        chk("lit_cnt", 32'(nif.cnt), 32'(ec));
        chk("lit_no_det", 32'(nif.no_det), 32'(en));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(nif.out_valid), 32'd1);
            chk("hold_in_ready", 32'(nif.in_ready), 32'd0);
            chk("hold_z", 32'(nif.z), 32'(ez));
            chk("hold_cnt", 32'(nif.cnt), 32'(ec));
        end
        nif.out_ready = 1'b1;
        @(posedge clk); #1;
        nif.out_ready = 1'b0;
        chk("release_in_ready", 32'(nif.in_ready), 32'd1);
        chk("release_out_valid", 32'(nif.out_valid), 32'd0);
    endtask

    // Safety net against a stuck run.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t m;
        int   n;
        int   acc0;
        int   res0;
        nif.in_valid  = 1'b0;
        nif.a         = 8'h00;
        nif.out_ready = 1'b0;

        // Model pins
        m = model(8'h13); chk("pin_13_z", 32'(m.z), 32'h98); chk("pin_13_cnt", 32'(m.cnt), 32'd3);
        m = model(8'h00); chk("pin_00_cnt", 32'(m.cnt), 32'd8); chk("pin_00_nd", 32'(m.nd), 32'd1);
        m = model(8'h01); chk("pin_01_z", 32'(m.z), 32'h80);

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(nif.in_ready), 32'd1);
        chk("rst_out_valid", 32'(nif.out_valid), 32'd0);
        chk("rst_z", 32'(nif.z), 32'd0);
        chk("rst_cnt", 32'(nif.cnt), 32'd0);
        chk("rst_no_det", 32'(nif.no_det), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed words
        send(8'h01, 8'h80, 4'd7, 1'b0, 4, 0);
        send(8'h00, 8'h00, 4'd8, 1'b1, 1, 0);
        send(8'hA5, 8'hA5, 4'd0, 1'b0, 4, 0);
        send(8'h13, 8'h98, 4'd3, 1'b0, 4, 5);
        send(8'h7F, 8'hFE, 4'd1, 1'b0, 4, 1);
        send(8'h02, 8'h80, 4'd6, 1'b0, 4, 0);

        // Reset in the middle of SHIFT discards the word
        nif.a = 8'h13; nif.in_valid = 1'b1;
        @(posedge clk); #1;
        nif.in_valid = 1'b0;
        @(posedge clk); #1;
        res0 = res_cnt;
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(nif.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(nif.out_valid), 32'd0);
        chk("midrst_z", 32'(nif.z), 32'd0);
        chk("midrst_cnt", 32'(nif.cnt), 32'd0);
        chk("midrst_no_det", 32'(nif.no_det), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("discarded_no_result", 32'(nif.out_valid), 32'd0);
        end
        chk("discarded_res_count", 32'(res_cnt - res0), 32'd0);
        send(8'h40, 8'h80, 4'd1, 1'b0, 4, 0);

        // Sweep of all values with random gaps and back-pressure
        acc0 = acc_cnt;
        res0 = res_cnt;
        for (int v = 0; v < 256; v++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                nif.in_valid  = 1'b0;
                nif.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            n = 0;
            while (!nif.in_ready && n < 100) begin
                nif.in_valid  = 1'($urandom_range(0, 1));
                nif.a         = 8'($urandom);
                nif.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                n++;
            end
            if (n >= 100) chk("sweep_wait_idle", 32'd0, 32'd1);
            nif.in_valid  = 1'b1;
            nif.a         = 8'(v);
            nif.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            nif.in_valid = 1'b0;
        end
        nif.out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        nif.out_ready = 1'b0;
        chk("sweep_accepted", 32'(acc_cnt - acc0), 32'd256);
        chk("sweep_results", 32'(res_cnt - res0), 32'd256);
        chk("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_au_normalize_seq
